// File: rtl/disp_sg_mag_pkg.sv
// Shared constants for the sign-magnitude display stage.
// Holds the active-low segment encodings ({dp,g,f,e,d,c,b,a}), the anode
// width and the meaning of each scan slot. No ports.
package disp_sg_mag_pkg;

    localparam int AN_W = 4;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    // Scan slot meaning; slot 0 is the rightmost digit.
    localparam logic [1:0] SLOT_UNITS = 2'd0;
    localparam logic [1:0] SLOT_TENS  = 2'd1;
    localparam logic [1:0] SLOT_SIGN  = 2'd2;
    localparam logic [1:0] SLOT_PAD   = 2'd3;

    // Digit code that bcd_7seg renders as a dark digit.
    localparam logic [3:0] DIGIT_BLANK = 4'd15;

    // Active-low pattern for a decimal digit, dp off; codes 10..15 are dark.
    function automatic logic [7:0] digit_pattern(input logic [3:0] digit);
        logic [7:0] pat;
        case (digit)
            4'd0:    pat = 8'hC0;
            4'd1:    pat = 8'hF9;
            4'd2:    pat = 8'hA4;
            4'd3:    pat = 8'hB0;
            4'd4:    pat = 8'h99;
            4'd5:    pat = 8'h92;
            4'd6:    pat = 8'h82;
            4'd7:    pat = 8'hF8;
            4'd8:    pat = 8'h80;
            4'd9:    pat = 8'h90;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/disp_sg_mag_bcd_7seg.sv
// bcd_7seg: combinational decimal digit to active-low 7-segment pattern.
// Ports:
//   digit  in  4  digit code, 0..9 shown, 10..15 dark
//   seg    out 8  {dp,g,f,e,d,c,b,a}, active-low, dp always off
module bcd_7seg
    import disp_sg_mag_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    // Table lookup of the segment pattern.
    always_comb begin
        seg = digit_pattern(digit);
    end

endmodule

// File: rtl/disp_sg_mag.sv
// disp_sg_mag: captures the sign-magnitude adder result on a load strobe and
// shows it in signed decimal on a 4-digit multiplexed common-anode display.
// Leading zero of the tens digit is blanked; negative zero shows no minus.
// Ports:
//   clk    in  1  system clock, rising edge
//   reset  in  1  synchronous, active-high
//   load   in  1  capture strobe for res/sg
//   res    in  4  magnitude 0..15
//   sg     in  1  sign, 1 = negative
//   an     out 4  anodes, active-low one-hot, bit 0 = rightmost digit
//   seg    out 8  segments {dp,g,f,e,d,c,b,a}, active-low
module disp_sg_mag
    import disp_sg_mag_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic [3:0]      res,
    input  logic            sg,
    output logic [AN_W-1:0] an,
    output logic [7:0]      seg
);

    localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [3:0]       mag_r;
    logic             neg_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       idx_r;

    logic             tick_s;
    logic             tens_s;
    logic [3:0]       units_s;
    logic [3:0]       digit_s;
    logic [7:0]       digit_seg_s;
    logic [7:0]       seg_next_s;
    logic [AN_W-1:0]  an_next_s;

    assign tick_s = (cnt_r == CNT_LAST);

    // Capture register; a zero magnitude is always stored as positive.
    always_ff @(posedge clk) begin
        if (reset) begin
            mag_r <= 4'd0;
            neg_r <= 1'b0;
        end else if (load) begin
            mag_r <= res;
            neg_r <= sg & (res != 4'd0);
        end else begin
            mag_r <= mag_r;
            neg_r <= neg_r;
        end
    end

    // Refresh divider and scan slot index.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= 2'd0;
        end else if (tick_s) begin
            cnt_r <= {CNT_W{1'b0}};
            idx_r <= idx_r + 2'd1;
        end else begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            idx_r <= idx_r;
        end
    end

    // Decimal split of a 0..15 magnitude: tens is at most 1.
    always_comb begin
        tens_s  = (mag_r >= 4'd10);
        if (tens_s) begin
            units_s = mag_r - 4'd10;
        end else begin
            units_s = mag_r;
        end
    end

    // Digit code for the decoder; slots without a numeral feed a dark code.
    always_comb begin
        case (idx_r)
            SLOT_UNITS: digit_s = units_s;
            SLOT_TENS:  digit_s = tens_s ? 4'd1 : DIGIT_BLANK;
            default:    digit_s = DIGIT_BLANK;
        endcase
    end

    bcd_7seg u_bcd_7seg (
        .digit (digit_s),
        .seg   (digit_seg_s)
    );

    // Final segment choice; the minus sign is not a decoder digit.
    always_comb begin
        an_next_s = ~(4'b0001 << idx_r);
        case (idx_r)
            SLOT_SIGN: seg_next_s = neg_r ? SEG_MINUS : SEG_BLANK;
            SLOT_PAD:  seg_next_s = SEG_BLANK;
            default:   seg_next_s = digit_seg_s;
        endcase
    end

    // Output register: anode and segments change on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= {AN_W{1'b1}};
            seg <= SEG_BLANK;
        end else begin
            an  <= an_next_s;
            seg <= seg_next_s;
        end
    end

endmodule

// File: tb/tb_disp_sg_mag.sv
module tb_disp_sg_mag;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [3:0] res = 4'd0;
    logic       sg = 1'b0;
    logic [3:0] an;
    logic [7:0] seg;

    int checks = 0;
    int errors = 0;

    // Reference model state: signed displayed value and non-reset edges since reset.
    int         mval = 0;
    int         nedge = 0;
    logic [3:0] exp_an;
    logic [7:0] exp_seg;
    logic [7:0] seen [0:3];

    disp_sg_mag #(.REFRESH_DIV(RD)) dut (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .res   (res),
        .sg    (sg),
        .an    (an),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pat(input int d);
        logic [7:0] t [0:9];
        t = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        return t[d];
    endfunction

    // What a signed value looks like on digit position d (0 = rightmost).
    function automatic logic [7:0] model_seg(input int d, input int v);
        int m;
        m = (v < 0) ? -v : v;
        if (d == 0) return pat(m % 10);
        if (d == 1) return (m >= 10) ? pat(m / 10) : 8'hFF;
        if (d == 2) return (v < 0) ? 8'hBF : 8'hFF;
        return 8'hFF;
    endfunction

    // Drive one cycle; leaves exp_an/exp_seg as the outputs expected after the edge.
    task automatic cyc(input logic r, input logic l, input logic [3:0] rv, input logic s);
        int d;
        reset = r; load = l; res = rv; sg = s;
        if (r) begin
            exp_an = 4'hF; exp_seg = 8'hFF;
            nedge = 0; mval = 0;
        end else begin
            d = (nedge / RD) % 4;
            exp_an = 4'hF ^ (4'(1) << d);
            exp_seg = model_seg(d, mval);
            nedge++;
            if (l) mval = s ? -int'(rv) : int'(rv);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic int slot_of(input logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return 4;
        endcase
    endfunction

    task automatic test_reset;
        logic [3:0] an_seq [0:3];
        an_seq = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, 1'b1, 4'd9, 1'b1);
            checks++;
            if (an !== 4'hF || seg !== 8'hFF) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: an=%b seg=%h, want an=1111 seg=ff", i, an, seg);
            end
        end
        for (int k = 0; k < 16; k++) begin
            cyc(1'b0, 1'b0, 4'd0, 1'b0);
            checks++;
            if (an !== an_seq[k / 4] || seg !== ((k < 4) ? 8'hC0 : 8'hFF)) begin
                errors++;
                $display("FAIL reset_scan k%0d: an=%b seg=%h, want an=%b seg=%h",
                         k, an, seg, an_seq[k / 4], (k < 4) ? 8'hC0 : 8'hFF);
            end
        end
    endtask

    // Load once, then watch a full frame against the model and record each digit.
    task automatic load_and_frame(input logic [3:0] rv, input logic s, input string nm);
        for (int i = 0; i < 4; i++) seen[i] = 8'h00;
        cyc(1'b0, 1'b1, rv, s);
        for (int i = 0; i < 4 * RD + 2; i++) begin
            cyc(1'b0, 1'b0, 4'd0, 1'b0);
            checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL %s cyc%0d: an=%b seg=%h, want an=%b seg=%h", nm, i, an, seg, exp_an, exp_seg);
            end
            if (slot_of(an) < 4) seen[slot_of(an)] = seg;
        end
    endtask

    task automatic test_load_neg5;
        load_and_frame(4'd5, 1'b1, "neg5");
        checks++;
        if (seen[0] !== 8'h92 || seen[1] !== 8'hFF || seen[2] !== 8'hBF || seen[3] !== 8'hFF) begin
            errors++;
            $display("FAIL neg5_digits: got %h %h %h %h, want 92 ff bf ff", seen[0], seen[1], seen[2], seen[3]);
        end
    endtask

    task automatic test_load_pos12;
        load_and_frame(4'd12, 1'b0, "pos12");
        checks++;
        if (seen[0] !== 8'hA4 || seen[1] !== 8'hF9 || seen[2] !== 8'hFF || seen[3] !== 8'hFF) begin
            errors++;
            $display("FAIL pos12_digits: got %h %h %h %h, want a4 f9 ff ff", seen[0], seen[1], seen[2], seen[3]);
        end
    endtask

    task automatic test_neg_zero;
        load_and_frame(4'd0, 1'b1, "negzero");
        checks++;
        if (seen[0] !== 8'hC0 || seen[2] !== 8'hFF) begin
            errors++;
            $display("FAIL negzero_digits: got d0=%h d2=%h, want c0 ff", seen[0], seen[2]);
        end
    endtask

    task automatic test_load_on_tick;
        int guard = 0;
        while ((nedge % RD) != RD - 1 && guard < 2 * RD) begin
            cyc(1'b0, 1'b0, 4'd0, 1'b0);
            guard++;
        end
        cyc(1'b0, 1'b1, 4'd14, 1'b1);  // load on the tick edge
        for (int i = 0; i < 4; i++) seen[i] = 8'h00;
        for (int i = 0; i < 4 * RD; i++) begin
            cyc(1'b0, 1'b0, 4'd0, 1'b0);
            checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL tick_load cyc%0d: an=%b seg=%h, want an=%b seg=%h", i, an, seg, exp_an, exp_seg);
            end
            if (slot_of(an) < 4) seen[slot_of(an)] = seg;
        end
        checks++;
        if (seen[0] !== 8'h99 || seen[1] !== 8'hF9 || seen[2] !== 8'hBF) begin
            errors++;
            $display("FAIL tick_load_digits: got %h %h %h, want 99 f9 bf", seen[0], seen[1], seen[2]);
        end
    endtask

    task automatic test_reset_mid_frame;
        int guard = 0;
        cyc(1'b0, 1'b1, 4'd12, 1'b1);
        while ((((nedge - 1) / RD) % 4) != 2 && guard < 8 * RD) begin
            cyc(1'b0, 1'b0, 4'd0, 1'b0);
            guard++;
        end
        checks++;
        if (an !== 4'b1011 || seg !== 8'hBF) begin
            errors++;
            $display("FAIL midreset_pre: an=%b seg=%h, want an=1011 seg=bf", an, seg);
        end
        cyc(1'b1, 1'b0, 4'd0, 1'b0);
        checks++;
        if (an !== 4'hF || seg !== 8'hFF) begin
            errors++;
            $display("FAIL midreset_hold: an=%b seg=%h, want an=1111 seg=ff", an, seg);
        end
        for (int k = 0; k < RD + 1; k++) begin
            cyc(1'b0, 1'b0, 4'd0, 1'b0);
            checks++;
            if (an !== ((k < RD) ? 4'b1110 : 4'b1101) || seg !== ((k < RD) ? 8'hC0 : 8'hFF)) begin
                errors++;
                $display("FAIL midreset_after k%0d: an=%b seg=%h", k, an, seg);
            end
        end
    endtask

    task automatic test_random;
        logic r, l, s;
        logic [3:0] rv;
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 59) == 0);
            l  = ($urandom_range(0, 3) == 0);
            rv = 4'($urandom_range(0, 15));
            s  = 1'($urandom_range(0, 1));
            cyc(r, l, rv, s);
            checks++;
            if (an !== exp_an || seg !== exp_seg) begin
                errors++;
                $display("FAIL random cyc%0d: an=%b seg=%h, want an=%b seg=%h", i, an, seg, exp_an, exp_seg);
            end
        end
    endtask

    initial begin
        test_reset;
        test_load_neg5;
        test_load_pos12;
        test_neg_zero;
        test_load_on_tick;
        test_reset_mid_frame;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
